// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and defaults for the two-slot shared multiplier.
// The arbiter FSM and the bench both import this package.
package mul_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int MUL_LAT_DEF = 3;
    localparam int TAG_W_DEF   = 5;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational and gated by en.
// The pointer moves to the non-granted slot whenever a grant is taken.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic ptr
);

    // ptr==0 prefers slot 0 when both request; ptr==1 prefers slot 1
    assign gnt0 = en && req0 && (!req1 || !ptr);
    assign gnt1 = en && req1 && (!req0 ||  ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency multiplier between two issue slots.
// One op in flight at a time; a decoded HLT drains the in-flight op, then parks.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    input  logic             hlt,
    output logic             resp_valid,
    output logic             resp_slot,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    output logic             busy,
    output logic             halted
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               halt_pend;
    logic               accept_en;
    logic               gnt0, gnt1, accept;
    logic               rr_ptr;
    logic [31:0]        op_a, op_b;
    logic [TAG_W-1:0]   op_tag;
    logic               op_slot;
    logic [31:0]        prod;

    // A halt seen this cycle already blocks acceptance, as does reset
    assign accept_en = (state == IDLE) && !hlt && !halt_pend && !rst;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (accept_en),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .ptr  (rr_ptr)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;

    // Low 32 bits of the product are identical for signed and unsigned operands
    assign prod = op_a * op_b;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (hlt || halt_pend) begin
                    state_nxt = HALTED;
                end else if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(MUL_LAT - 2);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = (hlt || halt_pend) ? HALTED : IDLE;
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            halt_pend  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_tag     <= '0;
            op_slot    <= 1'b0;
            resp_valid <= 1'b0;
            resp_slot  <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hlt) begin
                halt_pend <= 1'b1;
            end
            if (accept) begin
                op_slot <= gnt1;
                op_a    <= gnt1 ? req1_a   : req0_a;
                op_b    <= gnt1 ? req1_b   : req0_b;
                op_tag  <= gnt1 ? req1_tag : req0_tag;
            end
            // Response fields only change when a result is published, so they hold otherwise
            resp_valid <= (state == BUSY) && (state_nxt == DONE);
            if ((state == BUSY) && (state_nxt == DONE)) begin
                resp_slot <= op_slot;
                resp_tag  <= op_tag;
                resp_data <= prod;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: single op, contention, overflow,
// halt in flight, halt vs request, reset mid-op.
module tb_mul_share_arbiter;
    import mul_share_arbiter_pkg::*;

    localparam int LAT = 3;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          req0_ready, req1_ready;
    logic          hlt;
    logic          resp_valid, resp_slot;
    logic [TW-1:0] resp_tag;
    logic [31:0]   resp_data;
    logic          busy, halted;

    int n_chk = 0;
    int n_err = 0;

    mul_share_arbiter #(.MUL_LAT(LAT), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .req1_ready (req1_ready),
        .hlt        (hlt),
        .resp_valid (resp_valid),
        .resp_slot  (resp_slot),
        .resp_tag   (resp_tag),
        .resp_data  (resp_data),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        hlt        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst.rdy0", 32'(req0_ready), 32'd0);
        chk("rst.rdy1", 32'(req1_ready), 32'd0);
        step;
        step;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b0;
    endtask

    // Present requests in the current cycle, expect the given slot to win,
    // then follow the op to its response. Inputs are scrambled after accept.
    task automatic xact(input string nm, input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [TW-1:0] t0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [TW-1:0] t1,
                        input logic exp_slot, input logic [TW-1:0] exp_tag, input logic [31:0] exp_data);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_tag = t0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_tag = t1;
        #1;
        chk({nm, ".rdy0"}, 32'(req0_ready), 32'(exp_slot == 1'b0));
        chk({nm, ".rdy1"}, 32'(req1_ready), 32'(exp_slot == 1'b1));
        step;
        req0_a = ~a0; req0_b = a1 ^ 32'h5a5a; req0_tag = ~t0;
        req1_a = ~a1; req1_b = b0 + 32'd3;    req1_tag = ~t1;
        for (int k = 1; k < LAT; k++) begin
            chk({nm, ".bsy_rv"}, 32'(resp_valid), 32'd0);
            chk({nm, ".bsy"}, 32'(busy), 32'd1);
            chk({nm, ".bsy_rdy"}, 32'(req0_ready | req1_ready), 32'd0);
            step;
        end
        chk({nm, ".rv"}, 32'(resp_valid), 32'd1);
        chk({nm, ".slot"}, 32'(resp_slot), 32'(exp_slot));
        chk({nm, ".tag"}, 32'(resp_tag), 32'(exp_tag));
        chk({nm, ".data"}, resp_data, exp_data);
        chk({nm, ".done_rdy"}, 32'(req0_ready | req1_ready), 32'd0);
        step;
        chk({nm, ".rv_off"}, 32'(resp_valid), 32'd0);
        chk({nm, ".hold"}, resp_data, exp_data);
        chk({nm, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; hlt = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;

        do_reset;
        chk("rst.rv", 32'(resp_valid), 32'd0);
        chk("rst.slot", 32'(resp_slot), 32'd0);
        chk("rst.tag", 32'(resp_tag), 32'd0);
        chk("rst.data", resp_data, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);

        // single op: 7*6
        xact("single", 1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 32'd0, 32'd0, 5'd0, 1'b0, 5'd3, 32'd42);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // contention from reset: 0, 1, 0
        do_reset;
        xact("cont0", 1'b1, 1'b1, 32'd3, 32'd5, 5'd1, 32'd10, 32'd11, 5'd2, 1'b0, 5'd1, 32'd15);
        xact("cont1", 1'b1, 1'b1, 32'd3, 32'd5, 5'd1, 32'd10, 32'd11, 5'd2, 1'b1, 5'd2, 32'd110);
        xact("cont2", 1'b1, 1'b1, 32'd3, 32'd5, 5'd1, 32'd10, 32'd11, 5'd2, 1'b0, 5'd1, 32'd15);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // overflow truncation
        xact("ovf0", 1'b1, 1'b0, 32'h8000_0000, 32'd2, 5'd9, 32'd0, 32'd0, 5'd0, 1'b0, 5'd9, 32'h0000_0000);
        xact("ovf1", 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 5'd31, 32'h0000_0001);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // halt while op in flight
        do_reset;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_tag = 5'd4;
        #1;
        chk("hif.rdy0", 32'(req0_ready), 32'd1);
        step;
        req0_valid = 1'b0; hlt = 1'b1;
        chk("hif.busy", 32'(busy), 32'd1);
        step;
        hlt = 1'b0;
        chk("hif.rv_t2", 32'(resp_valid), 32'd0);
        step;
        chk("hif.rv_t3", 32'(resp_valid), 32'd1);
        chk("hif.data", resp_data, 32'd81);
        chk("hif.tag", 32'(resp_tag), 32'd4);
        chk("hif.halted_t3", 32'(halted), 32'd0);
        step;
        chk("hif.halted_t4", 32'(halted), 32'd1);
        chk("hif.rv_t4", 32'(resp_valid), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hif.park_rdy", 32'(req0_ready | req1_ready), 32'd0);
            chk("hif.park_h", 32'(halted), 32'd1);
            chk("hif.park_rv", 32'(resp_valid), 32'd0);
            step;
        end

        // halt and request together in IDLE
        do_reset;
        hlt = 1'b1; req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_tag = 5'd6;
        #1;
        chk("hvr.rdy1", 32'(req1_ready), 32'd0);
        chk("hvr.rdy0", 32'(req0_ready), 32'd0);
        step;
        hlt = 1'b0;
        chk("hvr.halted", 32'(halted), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("hvr.rv", 32'(resp_valid), 32'd0);
            chk("hvr.rdy", 32'(req1_ready), 32'd0);
            step;
        end
        req1_valid = 1'b0;
        do_reset;
        chk("hvr.unhalt", 32'(halted), 32'd0);

        // reset mid-op discards the op; new accept right after
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_tag = 5'd8;
        #1;
        chk("rmo.rdy0", 32'(req0_ready), 32'd1);
        step;
        rst = 1'b1;
        #1;
        chk("rmo.rst_rdy", 32'(req0_ready), 32'd0);
        step;
        rst = 1'b0;
        chk("rmo.rv", 32'(resp_valid), 32'd0);
        chk("rmo.data", resp_data, 32'd0);
        chk("rmo.tag", 32'(resp_tag), 32'd0);
        chk("rmo.busy", 32'(busy), 32'd0);
        xact("rmo.new", 1'b1, 1'b0, 32'd2, 32'd3, 5'd7, 32'd0, 32'd0, 5'd0, 1'b0, 5'd7, 32'd6);
        req0_valid = 1'b0;
        step;
        chk("rmo.tail_rv", 32'(resp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
